// File: rtl/product_reg_reader.sv
`default_nettype none
// ============================================================================
//  Module      : product_reg_reader
//  Description : Reads a 65-bit product register over a shared tri-state bus.
//                The read enable (oe) is raised and held for SETTLE_CYCLES
//                cycles so the bus can settle, the bus is then sampled once,
//                and the 32-bit result bus_in[32:1] is presented with a
//                valid/ready handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE_CYCLES  cycles oe is held before sampling (1..15; 0 acts as 1,
//                   values above 15 act as 15)
//  Optional build macro
//    PRODUCT_OVF_CHECK_EN  when defined, ovf flags products that do not fit
//                          in a signed 32-bit value; otherwise ovf is tied 0
//  Ports
//    clk           in   1   clock, rising-edge active
//    clr_n         in   1   asynchronous active-low reset
//    start         in   1   read request, honoured only when idle
//    busy          out  1   high whenever the FSM is not idle
//    oe            out  1   product register output enable (registered)
//    bus_in        in  65   shared bus from the product register
//    result        out 32   captured bus_in[32:1]
//    ovf           out  1   signed 32-bit overflow of the captured product
//    result_valid  out  1   result/ovf valid
//    result_ready  in   1   consumer accepts result
// ============================================================================
module product_reg_reader #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    output logic        busy,
    output logic        oe,
    input  logic [64:0] bus_in,
    output logic [31:0] result,
    output logic        ovf,
    output logic        result_valid,
    input  logic        result_ready
);

    // Effective settle length; 0 behaves as 1 and the 4-bit counter caps at 15.
    localparam int         c_SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1  :
                                          (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] c_CNT_LOAD   = 4'(c_SETTLE_EFF - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ENABLE = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_VALID  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_oe;
    logic [31:0] r_result;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_ENABLE;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            c_ST_ENABLE: begin
                // Counter was loaded with settle-1, so ENABLE lasts exactly
                // c_SETTLE_EFF cycles before the single SAMPLE cycle.
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = c_ST_SAMPLE;
                end
            end
            c_ST_SAMPLE: begin
                w_state_nxt = c_ST_VALID;
            end
            c_ST_VALID: begin
                // start is deliberately not looked at here: a request that
                // coincides with the handshake is dropped.
                if (result_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counter and output-enable registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // oe registered from the next state so it is glitch-free and
            // aligned exactly with the ENABLE/SAMPLE states.
            r_oe    <= (w_state_nxt == c_ST_ENABLE) || (w_state_nxt == c_ST_SAMPLE);
        end
    end

    // ------------------------------------------------------------------------
    // Result capture: only in SAMPLE, held otherwise (including after the
    // handshake, so the last value stays visible).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_result <= 32'h0;
        end else if (r_state == c_ST_SAMPLE) begin
            r_result <= bus_in[32:1];
        end
    end

`ifdef PRODUCT_OVF_CHECK_EN
    // The product fits in a signed 32-bit value only when bits 64..33 are a
    // sign extension of bit 32, i.e. bits 64..32 are all ones or all zeros.
    logic w_ovf_nxt;
    logic r_ovf;
    logic w_unused_bit0;

    assign w_ovf_nxt     = !((&bus_in[64:32]) || !(|bus_in[64:32]));
    assign w_unused_bit0 = bus_in[0];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == c_ST_SAMPLE) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`else
    // Upper bits and bit 0 carry no information without the overflow check.
    logic [32:0] w_unused_bits;

    assign w_unused_bits = {bus_in[64:33], bus_in[0]};
    assign ovf           = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs; all derive from asynchronously reset registers so they drop
    // immediately when clr_n asserts.
    // ------------------------------------------------------------------------
    assign busy         = (r_state != c_ST_IDLE);
    assign result_valid = (r_state == c_ST_VALID);
    assign oe           = r_oe;
    assign result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_product_reg_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_reg_reader
//  Description : Directed self-checking bench for product_reg_reader. One
//                instance uses the default settle length, a second uses
//                SETTLE_CYCLES=4. Both share clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_product_reg_reader;

    logic        clk;
    logic        clr_n;

    logic        start_a, ready_a;
    logic [64:0] bus_a;
    logic        busy_a, oe_a, ovf_a, valid_a;
    logic [31:0] result_a;

    logic        start_b, ready_b;
    logic [64:0] bus_b;
    logic        busy_b, oe_b, ovf_b, valid_b;
    logic [31:0] result_b;

    int checks   = 0;
    int failures = 0;

`ifdef PRODUCT_OVF_CHECK_EN
    localparam logic c_OVF_ON = 1'b1;
`else
    localparam logic c_OVF_ON = 1'b0;
`endif

    product_reg_reader u_dut_a (
        .clk          (clk),
        .clr_n        (clr_n),
        .start        (start_a),
        .busy         (busy_a),
        .oe           (oe_a),
        .bus_in       (bus_a),
        .result       (result_a),
        .ovf          (ovf_a),
        .result_valid (valid_a),
        .result_ready (ready_a)
    );

    product_reg_reader #(.SETTLE_CYCLES(4)) u_dut_b (
        .clk          (clk),
        .clr_n        (clr_n),
        .start        (start_b),
        .busy         (busy_b),
        .oe           (oe_b),
        .bus_in       (bus_b),
        .result       (result_b),
        .ovf          (ovf_b),
        .result_valid (valid_b),
        .result_ready (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on instance A; returns at the negedge of cycle 1.
    task automatic pulse_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    task automatic handshake_a();
        ready_a = 1'b1;
        @(negedge clk) ready_a = 1'b0;
    endtask

    initial begin
        int seen;
        clr_n   = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; bus_a = '0;
        start_b = 1'b0; ready_b = 1'b0; bus_b = '0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_busy",   busy_a,   1'b0);
        chk("rst_oe",     oe_a,     1'b0);
        chk("rst_valid",  valid_a,  1'b0);
        chk("rst_result", result_a, 32'h0);
        chk("rst_ovf",    ovf_a,    1'b0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;

        // ---------------- basic read, 0x0A -> 5 ----------------
        bus_a = 65'h0_0000_000A;
        pulse_a();
        chk("c1_oe",    oe_a,    1'b1);
        chk("c1_busy",  busy_a,  1'b1);
        chk("c1_valid", valid_a, 1'b0);
        @(negedge clk);
        chk("c2_oe",    oe_a,    1'b1);
        chk("c2_valid", valid_a, 1'b0);
        @(negedge clk);
        chk("c3_oe",     oe_a,     1'b0);
        chk("c3_valid",  valid_a,  1'b1);
        chk("c3_result", result_a, 32'h0000_0005);
        chk("c3_ovf",    ovf_a,    1'b0);
        handshake_a();
        chk("hs_busy",   busy_a,   1'b0);
        chk("hs_valid",  valid_a,  1'b0);
        chk("hs_retain", result_a, 32'h0000_0005);

        // ---------------- negative product, hold in VALID ----------------
        bus_a = 65'h1_FFFF_FFFF_FFFF_FFFC;
        pulse_a();
        @(negedge clk);
        @(negedge clk);
        chk("neg_valid",  valid_a,  1'b1);
        chk("neg_result", result_a, 32'hFFFF_FFFE);
        chk("neg_ovf",    ovf_a,    1'b0);
        for (int i = 0; i < 5; i++) begin
            bus_a   = {33'h0_1234_5678, 32'(i * 32'h1111_1111)};
            start_a = i[0];
            @(negedge clk);
            chk("hold_valid",  valid_a,  1'b1);
            chk("hold_result", result_a, 32'hFFFF_FFFE);
            chk("hold_oe",     oe_a,     1'b0);
            chk("hold_ovf",    ovf_a,    1'b0);
        end
        // start and result_ready together: back to IDLE, request dropped
        start_a = 1'b1;
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        ready_a = 1'b0;
        chk("drop_busy",  busy_a,  1'b0);
        chk("drop_valid", valid_a, 1'b0);
        @(negedge clk);
        chk("drop_busy2", busy_a,  1'b0);
        chk("drop_oe2",   oe_a,    1'b0);

        // ---------------- overflow pattern ----------------
        bus_a = 65'h0_0000_0002_0000_0000;
        pulse_a();
        @(negedge clk);
        @(negedge clk);
        chk("ovf_valid",  valid_a,  1'b1);
        chk("ovf_result", result_a, 32'h0000_0000);
        chk("ovf_flag",   ovf_a,    c_OVF_ON);
        handshake_a();

        // ---------------- SETTLE_CYCLES=4 timing ----------------
        bus_b = 65'h0_0000_0000_0000_0100;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("s4_oe",    oe_b,    (c <= 5) ? 1'b1 : 1'b0);
            chk("s4_valid", valid_b, (c == 6) ? 1'b1 : 1'b0);
            if (c < 6) @(negedge clk);
        end
        chk("s4_result", result_b, 32'h0000_0080);
        ready_b = 1'b1;
        @(negedge clk) ready_b = 1'b0;
        chk("s4_idle", busy_b, 1'b0);

        // ---------------- reset during ENABLE ----------------
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        @(negedge clk);
        chk("ab_pre_oe", oe_b, 1'b1);
        @(posedge clk);
        #3 clr_n = 1'b0;
        #1;
        chk("ab_oe",   oe_b,   1'b0);
        chk("ab_busy", busy_b, 1'b0);
        @(negedge clk) clr_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_b) seen++;
        end
        chk("ab_no_valid", 64'(seen), 64'd0);
        chk("ab_busy_after", busy_b, 1'b0);
        chk("ab_result_clr", result_b, 32'h0);

        // ---------------- normal operation after reset ----------------
        bus_a = 65'h0_0000_0000_0000_0014;
        pulse_a();
        @(negedge clk);
        @(negedge clk);
        chk("post_valid",  valid_a,  1'b1);
        chk("post_result", result_a, 32'h0000_000A);
        handshake_a();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
